// File: rtl/tkm_pkg.sv
// Shared definitions for the bit-serial accumulator stage.
//   state_t        : FSM encoding (IDLE, ACC, HOLD), also exported on the debug port
//   TKM_ACC_WIDTH  : default maximum operand bits per frame
package tkm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int TKM_ACC_WIDTH = 6;

endpackage

// File: rtl/tkm_serial_acc_if.sv
// Bus bundle between the half-adder, the serial accumulator and the consumer.
//   master : bit producer + result consumer (drives bits, out_ready)
//   slave  : accumulator (drives bit_ready, results)
//
// Handshake semantics (both channels):
//   A transfer happens on a rising clk edge where valid & ready are both 1.
//   Once valid is raised with a result, the payload stays stable until the
//   transfer; ready may be toggled freely and never depends on valid.
interface tkm_serial_acc_if #(
    parameter int WIDTH = tkm_pkg::TKM_ACC_WIDTH
) ();
    localparam int CNT_W = $clog2(WIDTH + 1);

    // bit channel
    logic             bit_valid;
    logic             bit_first;
    logic             bit_last;
    logic             ha_sum;
    logic             ha_carry;
    logic             bit_ready;

    // result channel
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum_o;
    logic             cout_o;
    logic [CNT_W-1:0] len_o;

    modport master (
        output bit_valid, bit_first, bit_last, ha_sum, ha_carry, out_ready,
        input  bit_ready, out_valid, sum_o, cout_o, len_o
    );

    modport slave (
        input  bit_valid, bit_first, bit_last, ha_sum, ha_carry, out_ready,
        output bit_ready, out_valid, sum_o, cout_o, len_o
    );
endinterface

// File: rtl/tkm_fa_cell.sv
// Completes a full add from a half-adder pair, owning the running carry flop.
//   clk, rst_n        : clock, synchronous active-low reset
//   ha_sum, ha_carry  : half-adder result for the current bit position
//   clr               : current bit starts a frame, incoming carry forced to 0
//   en                : current bit is consumed, carry flop takes c_next
//   s, c_next         : full-add sum and carry for the current bit
module tkm_fa_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic ha_sum,
    input  logic ha_carry,
    input  logic clr,
    input  logic en,
    output logic s,
    output logic c_next
);
    logic carry;
    logic c_in;

    // A new frame ignores whatever carry the previous frame left behind.
    assign c_in   = carry & ~clr;
    assign s      = ha_sum ^ c_in;
    assign c_next = ha_carry | (ha_sum & c_in);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry <= 1'b0;
        end else if (en) begin
            carry <= c_next;
        end
    end
endmodule

// File: rtl/tkm_serial_acc.sv
// Bit-serial adder stage: takes half-adder sum/carry pairs LSB first, closes
// the add with a carry flop and presents the result word, carry-out and frame
// length on a valid/ready result channel.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : bit channel in, result channel out (slave side)
//   err_clr    : clears the sticky framing error
//   err_o      : sticky framing error (stray bit, restart mid-frame, overlong frame)
//   dbg_state  : current FSM state
module tkm_serial_acc
    import tkm_pkg::*;
#(
    parameter int WIDTH = TKM_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tkm_serial_acc_if.slave       bus,
    input  logic                  err_clr,
    output logic                  err_o,
    output state_t                dbg_state
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic [CNT_W-1:0] len_reg;
    logic             err_reg;

    logic             accept;
    logic             start;     // accepted bit_first: fresh frame at position 0
    logic             wr;        // accepted continuation bit at position cnt
    logic             close;     // this accepted bit ends the frame
    logic             set_err;
    logic             last_pos;  // cnt points at the final storable position
    logic             fa_s;
    logic             fa_c_next;

    assign bus.bit_ready = (state != HOLD);
    assign accept        = bus.bit_valid & bus.bit_ready;
    assign last_pos      = (cnt == CNT_W'(WIDTH - 1));

    tkm_fa_cell u_fa (
        .clk      (clk),
        .rst_n    (rst_n),
        .ha_sum   (bus.ha_sum),
        .ha_carry (bus.ha_carry),
        .clr      (start),
        .en       (start | wr),
        .s        (fa_s),
        .c_next   (fa_c_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        wr         = 1'b0;
        close      = 1'b0;
        set_err    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.bit_first) begin
                        start      = 1'b1;
                        close      = bus.bit_last;
                        state_next = bus.bit_last ? HOLD : ACC;
                    end else begin
                        // stray bit outside a frame is dropped
                        set_err = 1'b1;
                    end
                end
            end
            ACC: begin
                if (accept) begin
                    if (bus.bit_first) begin
                        // restart discards the partial frame
                        set_err    = 1'b1;
                        start      = 1'b1;
                        close      = bus.bit_last;
                        state_next = bus.bit_last ? HOLD : ACC;
                    end else begin
                        wr = 1'b1;
                        if (bus.bit_last || last_pos) begin
                            close      = 1'b1;
                            state_next = HOLD;
                            // register is full but producer did not mark the end
                            set_err    = ~bus.bit_last;
                        end
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
            len_reg  <= '0;
            err_reg  <= 1'b0;
        end else begin
            if (start) begin
                // clearing the word keeps unwritten upper bits at zero
                sum_reg <= WIDTH'(fa_s);
                cnt     <= CNT_W'(1);
            end else if (wr) begin
                sum_reg <= sum_reg | (WIDTH'(fa_s) << cnt);
                cnt     <= cnt + CNT_W'(1);
            end

            if (close) begin
                cout_reg <= fa_c_next;
                len_reg  <= start ? CNT_W'(1) : cnt + CNT_W'(1);
            end

            // a new error in the same cycle as a clear must survive
            if (set_err) begin
                err_reg <= 1'b1;
            end else if (err_clr) begin
                err_reg <= 1'b0;
            end
        end
    end

    assign bus.out_valid = (state == HOLD);
    assign bus.sum_o     = sum_reg;
    assign bus.cout_o    = cout_reg;
    assign bus.len_o     = len_reg;
    assign err_o         = err_reg;
    assign dbg_state     = state;
endmodule

// File: tb/tb_tkm_serial_acc.sv
module tb_tkm_serial_acc;
    import tkm_pkg::*;

    localparam int WIDTH = 6;
    localparam int CNT_W = 3;

    logic   clk = 1'b0;
    logic   rst_n;
    logic   err_clr;
    logic   err_o;
    state_t dbg_state;

    tkm_serial_acc_if #(.WIDTH(WIDTH)) bus ();

    tkm_serial_acc #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .err_clr   (err_clr),
        .err_o     (err_o),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    logic [WIDTH-1:0] exp_q[$];

    typedef struct {
        logic [7:0]       a;
        logic [7:0]       b;
        int               nbits;
        int               gap;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_cout;
        logic [CNT_W-1:0] exp_len;
    } vec_t;

    vec_t vecs[7];

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_bus();
        bus.bit_valid = 1'b0;
        bus.bit_first = 1'b0;
        bus.bit_last  = 1'b0;
        bus.ha_sum    = 1'b0;
        bus.ha_carry  = 1'b0;
    endtask

    // Half-adder model feeding one operand bit pair; waits for bit_ready.
    task automatic send_bit(input logic a_bit, input logic b_bit, input logic first, input logic last);
        int budget;
        budget        = 0;
        bus.bit_valid = 1'b1;
        bus.bit_first = first;
        bus.bit_last  = last;
        bus.ha_sum    = a_bit ^ b_bit;
        bus.ha_carry  = a_bit & b_bit;
        while (!bus.bit_ready && budget < 20) begin
            tick();
            budget++;
        end
        if (!bus.bit_ready) begin
            check("bit_ready_wait", 32'(bus.bit_ready), 32'd1);
        end
        tick();
        idle_bus();
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input int nbits,
                              input bit with_last, input int gap);
        for (int i = 0; i < nbits; i++) begin
            send_bit(a[i], b[i], i == 0, with_last && (i == nbits - 1));
            if (i < nbits - 1) begin
                for (int g = 0; g < gap; g++) tick();
            end
        end
    endtask

    task automatic check_result(input string tag, input logic [WIDTH-1:0] s,
                                input logic c, input logic [CNT_W-1:0] l, input logic e);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_sum"},   32'(bus.sum_o),     32'(s));
        check({tag, "_cout"},  32'(bus.cout_o),    32'(c));
        check({tag, "_len"},   32'(bus.len_o),     32'(l));
        check({tag, "_err"},   32'(err_o),         32'(e));
    endtask

    // ---------------- test ----------------
    initial begin
        vecs[0] = '{a: 8'd5,  b: 8'd3,  nbits: 6, gap: 0, exp_sum: 6'd8,  exp_cout: 1'b0, exp_len: 3'd6};
        vecs[1] = '{a: 8'd63, b: 8'd1,  nbits: 6, gap: 0, exp_sum: 6'd0,  exp_cout: 1'b1, exp_len: 3'd6};
        vecs[2] = '{a: 8'd7,  b: 8'd1,  nbits: 3, gap: 0, exp_sum: 6'd0,  exp_cout: 1'b1, exp_len: 3'd3};
        vecs[3] = '{a: 8'd7,  b: 8'd1,  nbits: 3, gap: 2, exp_sum: 6'd0,  exp_cout: 1'b1, exp_len: 3'd3};
        vecs[4] = '{a: 8'd10, b: 8'd12, nbits: 4, gap: 1, exp_sum: 6'd6,  exp_cout: 1'b1, exp_len: 3'd4};
        vecs[5] = '{a: 8'd1,  b: 8'd0,  nbits: 1, gap: 0, exp_sum: 6'd1,  exp_cout: 1'b0, exp_len: 3'd1};
        vecs[6] = '{a: 8'd21, b: 8'd42, nbits: 6, gap: 0, exp_sum: 6'd63, exp_cout: 1'b0, exp_len: 3'd6};

        // reset
        idle_bus();
        bus.out_ready = 1'b0;
        err_clr       = 1'b0;
        rst_n         = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_ready", 32'(bus.bit_ready), 32'd1);
        check("rst_sum",   32'(bus.sum_o),     32'd0);
        check("rst_cout",  32'(bus.cout_o),    32'd0);
        check("rst_len",   32'(bus.len_o),     32'd0);
        check("rst_err",   32'(err_o),         32'd0);
        check("rst_state", 32'(dbg_state),     32'(IDLE));
        rst_n = 1'b1;
        tick();

        // table-driven frames, consumer always ready
        bus.out_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            exp_q.push_back(vecs[v].exp_sum);
            send_frame(vecs[v].a, vecs[v].b, vecs[v].nbits, 1'b1, vecs[v].gap);
            check_result($sformatf("vec%0d", v), exp_q.pop_front(),
                         vecs[v].exp_cout, vecs[v].exp_len, 1'b0);
            tick();
            check($sformatf("vec%0d_valid_drop", v), 32'(bus.out_valid), 32'd0);
        end

        // result held while the consumer stalls and bits keep arriving
        bus.out_ready = 1'b0;
        send_frame(8'd7, 8'd1, 3, 1'b1, 0);
        check_result("hold_start", 6'd0, 1'b1, 3'd3, 1'b0);
        for (int k = 0; k < 5; k++) begin
            bus.bit_valid = 1'b1;
            bus.bit_first = 1'b1;
            bus.bit_last  = 1'b0;
            bus.ha_sum    = 1'b1;
            bus.ha_carry  = 1'b0;
            check("hold_bit_ready", 32'(bus.bit_ready), 32'd0);
            tick();
            check_result("hold_stable", 6'd0, 1'b1, 3'd3, 1'b0);
            check("hold_state", 32'(dbg_state), 32'(HOLD));
        end
        idle_bus();
        bus.out_ready = 1'b1;
        tick();
        check("hold_release", 32'(bus.out_valid), 32'd0);
        send_frame(8'd1, 8'd1, 2, 1'b1, 0);
        check_result("after_hold", 6'd2, 1'b0, 3'd2, 1'b0);
        tick();

        // restart mid-frame: partial 3+3 leaves carry set, new frame must ignore it
        send_frame(8'd3, 8'd3, 2, 1'b0, 0);
        send_frame(8'd1, 8'd0, 2, 1'b1, 0);
        check_result("restart", 6'd1, 1'b0, 3'd2, 1'b1);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("restart_clr", 32'(err_o), 32'd0);

        // stray bit in IDLE
        send_bit(1'b1, 1'b0, 1'b0, 1'b0);
        check("stray_err",   32'(err_o),         32'd1);
        check("stray_valid", 32'(bus.out_valid), 32'd0);
        check("stray_state", 32'(dbg_state),     32'(IDLE));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("stray_clr", 32'(err_o), 32'd0);

        // set wins over clear
        err_clr = 1'b1;
        send_bit(1'b1, 1'b1, 1'b0, 1'b0);
        err_clr = 1'b0;
        check("set_wins", 32'(err_o), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("set_wins_clr", 32'(err_o), 32'd0);

        // overlong frame: closes after WIDTH bits, extra bit dropped
        send_frame(8'd1, 8'd2, 6, 1'b0, 0);
        check_result("overlong", 6'd3, 1'b0, 3'd6, 1'b1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("overlong_clr",   32'(err_o),         32'd0);
        check("overlong_valid", 32'(bus.out_valid), 32'd0);
        send_bit(1'b0, 1'b0, 1'b0, 1'b0);
        check("seventh_err",   32'(err_o),         32'd1);
        check("seventh_valid", 32'(bus.out_valid), 32'd0);

        // reset in the middle of a frame (err_o still set from above)
        send_frame(8'd5, 8'd5, 3, 1'b0, 0);
        check("mid_state", 32'(dbg_state), 32'(ACC));
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_ready", 32'(bus.bit_ready), 32'd1);
        check("mid_rst_sum",   32'(bus.sum_o),     32'd0);
        check("mid_rst_cout",  32'(bus.cout_o),    32'd0);
        check("mid_rst_len",   32'(bus.len_o),     32'd0);
        check("mid_rst_err",   32'(err_o),         32'd0);
        rst_n = 1'b1;
        send_frame(8'd2, 8'd2, 3, 1'b1, 0);
        check_result("post_rst", 6'd4, 1'b0, 3'd3, 1'b0);
        tick();
        check("post_rst_drop", 32'(bus.out_valid), 32'd0);

        // report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
